// File: rtl/dram_tg_pkg.sv
// Shared definitions for the DRAM traffic generator/checker:
//   tg_mode_e    - run mode encoding as presented on the mode port
//   tg_state_e   - controller FSM states
//   GOLDEN       - per-word scrambling constant for the data pattern
//   pattern_word - one 32-bit word of the address-derived data pattern;
//                  callers assemble DATA_W/32 words into the full burst
package dram_tg_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ        = 2'd0,
    MODE_SCATTER    = 2'd1,
    MODE_WRITE_ONLY = 2'd2,
    MODE_READ_ONLY  = 2'd3
  } tg_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    WAIT_ACK,
    NEXT,
    DONE
  } tg_state_e;

  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

  // Word j of the burst for address addr32 (address already zero-extended).
  function automatic logic [31:0] pattern_word(input logic [31:0] addr32,
                                               input logic [31:0] seed,
                                               input int unsigned j);
    return addr32 ^ seed ^ (32'(j) * GOLDEN);
  endfunction

endpackage

// File: rtl/dram_tg_addr_gen.sv
// Registered address accumulator.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   load          - capture base and restart the walk from it
//   restart       - return to the captured base (start of the next phase)
//   step_en       - advance by step (wraps modulo 2^ADDR_W)
//   base, step    - first address and per-transaction increment
//   addr          - current transaction address
module dram_tg_addr_gen #(
  parameter int unsigned ADDR_W = 27
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              restart,
  input  logic              step_en,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q <= '0;
      addr   <= '0;
    end else if (load) begin
      base_q <= base;
      addr   <= base;
    end else if (restart) begin
      addr <= base_q;
    end else if (step_en) begin
      addr <= addr + step;
    end
  end

endmodule

// File: rtl/dram_traffic_checker.sv
// Write/read-back traffic generator and checker for the DRAM controller's
// native request port. Expected read data is regenerated from the address,
// so no data storage is needed.
//   clk_i, rst_i            - clock, asynchronous active-high reset
//   start, abort            - run control pulses
//   mode, base_addr, num_txn- run configuration, latched on start
//   read, write, address,
//   write_data              - request to the controller
//   read_data, ack, busy    - controller response / readiness
//   running, done, pass,
//   timeout, error_count,
//   first_fail_addr         - run status and results
module dram_traffic_checker
  import dram_tg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 27,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned STRIDE       = 8,
  parameter int unsigned SCATTER_MULT = 40503,
  parameter logic [31:0] SEED         = 32'hA5C3_0F1E,
  parameter int unsigned TIMEOUT      = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_txn,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              ack,
  input  logic              busy,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  error_count,
  output logic [ADDR_W-1:0] first_fail_addr
);

  localparam int unsigned       TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] SEQ_STEP  = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] SCAT_STEP = ADDR_W'(STRIDE * SCATTER_MULT);

  tg_state_e         state, state_n;
  tg_mode_e          mode_q;
  logic [CNT_W-1:0]  num_q, k;
  logic              phase_rd, abort_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pat;
  logic              addr_load, addr_step, addr_restart;
  logic              tmo_hit, last, two_phase, req_active, mismatch;

  assign two_phase  = (mode_q == MODE_SEQ) || (mode_q == MODE_SCATTER);
  assign last       = (k + CNT_W'(1)) == num_q;
  assign req_active = (state == REQ) || (state == WAIT_ACK);
  assign mismatch   = read_data != pat;

  dram_tg_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (addr_load),
    .restart (addr_restart),
    .step_en (addr_step),
    .base    (base_addr),
    .step    ((mode_q == MODE_SCATTER) ? SCAT_STEP : SEQ_STEP),
    .addr    (addr)
  );

  always_comb begin
    pat = '0;
    for (int unsigned j = 0; j < DATA_W / 32; j++) begin
      pat[32*j +: 32] = pattern_word(32'(addr), SEED, j);
    end
  end

  always_comb begin
    state_n      = state;
    addr_load    = 1'b0;
    addr_step    = 1'b0;
    addr_restart = 1'b0;
    tmo_hit      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n   = ARM;
        addr_load = 1'b1;
      end
      ARM: begin
        if (num_q == '0)  state_n = DONE;
        else if (!busy)   state_n = REQ;
      end
      REQ: state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (ack) begin
          state_n = NEXT;
        end else if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_n = DONE;
        end
      end
      NEXT: begin
        if (abort_q) begin
          state_n = DONE;
        end else if (!last) begin
          addr_step = 1'b1;
          state_n   = ARM;
        end else if (!phase_rd && two_phase) begin
          addr_restart = 1'b1;
          state_n      = ARM;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      mode_q          <= MODE_SEQ;
      num_q           <= '0;
      k               <= '0;
      phase_rd        <= 1'b0;
      abort_q         <= 1'b0;
      tmo_cnt         <= '0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      error_count     <= '0;
      first_fail_addr <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          mode_q          <= tg_mode_e'(mode);
          num_q           <= num_txn;
          k               <= '0;
          phase_rd        <= (tg_mode_e'(mode) == MODE_READ_ONLY);
          abort_q         <= 1'b0;
          pass            <= 1'b0;
          timeout         <= 1'b0;
          error_count     <= '0;
          first_fail_addr <= '0;
        end
        ARM:           tmo_cnt <= '0;
        REQ, WAIT_ACK: tmo_cnt <= tmo_cnt + TMO_W'(1);
        NEXT: if (!abort_q) begin
          if (!last) begin
            k <= k + CNT_W'(1);
          end else if (!phase_rd && two_phase) begin
            k        <= '0;
            phase_rd <= 1'b1;
          end
        end
        default: ;
      endcase

      if (state == WAIT_ACK && ack && phase_rd && mismatch) begin
        if (error_count == '0) first_fail_addr <= addr;
        if (error_count != '1) error_count <= error_count + CNT_W'(1);
      end

      if (state != IDLE && state != DONE && abort) abort_q <= 1'b1;
      if (tmo_hit) timeout <= 1'b1;

      // Result is settled on the edge into DONE so pass is valid with done.
      // Any read mismatch was counted on an earlier edge (ACK -> NEXT).
      if (state_n == DONE && state != DONE)
        pass <= !tmo_hit && !abort_q && (error_count == '0);
    end
  end

  always_comb begin
    read       = req_active && phase_rd;
    write      = req_active && !phase_rd;
    address    = addr;
    write_data = write ? pat : '0;
    running    = (state == ARM) || req_active || (state == NEXT);
    done       = (state == DONE);
  end

endmodule
